// File: rtl/im_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
package im_arbiter_pkg;

    localparam logic [31:0] DEFAULT_BASE = 32'h0000_3000;
    localparam int unsigned DEFAULT_AW   = 12;
    localparam int unsigned DATA_W       = 32;

    // Owner of the access whose response is due next cycle.
    typedef enum logic [1:0] {
        TAG_IDLE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_LOAD  = 2'd2
    } tag_e;

    // Response-side record captured at grant time.
    typedef struct packed {
        tag_e tag;
        logic err;
        logic we;
    } resp_t;

endpackage

// File: rtl/im_addr_check.sv
// Maps a byte address onto an instruction-memory word index and flags
// addresses that are misaligned or outside the window.
module im_addr_check
    import im_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE = DEFAULT_BASE,
    parameter int unsigned AW   = DEFAULT_AW
) (
    input  logic [31:0]   addr,
    output logic          valid_c,
    output logic [AW-1:0] idx_c
);

    logic [31:0] offset;
    logic [31:0] upper;

    // Offset wraps mod 2^32, so addresses below BASE land far out of range.
    always_comb begin
        offset  = addr - BASE;
        upper   = offset >> (AW + 2);
        valid_c = (offset[1:0] == 2'b00) && (upper == 32'd0);
        idx_c   = offset[AW+1:2];
    end

endmodule

// File: rtl/im_arbiter.sv
// Two-port arbiter in front of a single-port synchronous instruction memory.
// Fetch has priority; the loader is forced through after STARVE_MAX waits.
module im_arbiter
    import im_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE       = DEFAULT_BASE,
    parameter int unsigned AW         = DEFAULT_AW,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_idx,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 2);

    logic          if_valid_c;
    logic [AW-1:0] if_idx_c;
    logic          ld_valid_c;
    logic [AW-1:0] ld_idx_c;

    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_next;
    logic          starved;
    resp_t         resp;
    resp_t         resp_next;

    im_addr_check #(.BASE(BASE), .AW(AW)) u_if_check (
        .addr    (if_addr),
        .valid_c (if_valid_c),
        .idx_c   (if_idx_c)
    );

    im_addr_check #(.BASE(BASE), .AW(AW)) u_ld_check (
        .addr    (ld_addr),
        .valid_c (ld_valid_c),
        .idx_c   (ld_idx_c)
    );

    assign starved = (starve_cnt == CW'(STARVE_MAX));

    // Grant selection, memory drive and next response record; all held low in reset.
    always_comb begin
        if_gnt        = 1'b0;
        ld_gnt        = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_idx       = '0;
        mem_wdata     = '0;
        starve_next   = '0;
        resp_next.tag = TAG_IDLE;
        resp_next.err = 1'b0;
        resp_next.we  = 1'b0;
        if (reset) begin
            if (ld_req && (!if_req || starved)) begin
                ld_gnt        = 1'b1;
                mem_en        = ld_valid_c;
                mem_we        = ld_valid_c && ld_we;
                mem_idx       = ld_valid_c ? ld_idx_c : '0;
                resp_next.tag = TAG_LOAD;
                resp_next.err = !ld_valid_c;
                resp_next.we  = ld_we;
            end else if (if_req) begin
                if_gnt        = 1'b1;
                mem_en        = if_valid_c;
                mem_idx       = if_valid_c ? if_idx_c : '0;
                resp_next.tag = TAG_FETCH;
                resp_next.err = !if_valid_c;
            end
            if (mem_en) begin
                mem_wdata = ld_wdata;
            end
            if (ld_req && !ld_gnt) begin
                starve_next = starved ? starve_cnt : starve_cnt + CW'(1);
            end
        end
    end

    // Starvation counter and in-flight response record.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            resp.tag   <= TAG_IDLE;
            resp.err   <= 1'b0;
            resp.we    <= 1'b0;
        end else begin
            starve_cnt <= starve_next;
            resp       <= resp_next;
        end
    end

    // Route the one-cycle-late response to its owner; errors and write acks return zero data.
    always_comb begin
        if_rvalid = 1'b0;
        if_err    = 1'b0;
        if_rdata  = '0;
        ld_rvalid = 1'b0;
        ld_err    = 1'b0;
        ld_rdata  = '0;
        case (resp.tag)
            TAG_FETCH: begin
                if_rvalid = 1'b1;
                if_err    = resp.err;
                if_rdata  = resp.err ? '0 : mem_rdata;
            end
            TAG_LOAD: begin
                ld_rvalid = 1'b1;
                ld_err    = resp.err;
                ld_rdata  = (resp.err || resp.we) ? '0 : mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_im_arbiter.sv
// Directed and randomized bench for im_arbiter against a transaction-level model.
module tb_im_arbiter;

    localparam int unsigned AW         = 12;
    localparam int unsigned WORDS      = 4096;
    localparam int unsigned STARVE_MAX = 4;
    localparam logic [31:0] BASE       = 32'h0000_3000;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          if_err;
    logic          ld_req;
    logic          ld_we;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [31:0]   ld_rdata;
    logic          ld_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'd0;

    logic [31:0] sim_mem [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: loader wait streak and the response expected next cycle.
    int          wait_cnt   = 0;
    int          pend_owner = 0;   // 0 none, 1 fetch, 2 loader
    logic        pend_err   = 1'b0;
    logic [31:0] pend_data  = 32'd0;

    im_arbiter #(.BASE(BASE), .AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .ld_rvalid (ld_rvalid),
        .ld_rdata  (ld_rdata),
        .ld_err    (ld_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_idx   (mem_idx),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory behind the arbiter.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sim_mem[mem_idx] <= mem_wdata;
            else        mem_rdata <= sim_mem[mem_idx];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off % 32'd4 == 32'd0) && (off < 32'(4 * WORDS));
    endfunction

    task automatic check_all_zero(input string where);
        check({where, ".if_gnt"},    32'(if_gnt),    32'd0);
        check({where, ".ld_gnt"},    32'(ld_gnt),    32'd0);
        check({where, ".if_rvalid"}, 32'(if_rvalid), 32'd0);
        check({where, ".ld_rvalid"}, 32'(ld_rvalid), 32'd0);
        check({where, ".if_err"},    32'(if_err),    32'd0);
        check({where, ".ld_err"},    32'(ld_err),    32'd0);
        check({where, ".if_rdata"},  if_rdata,       32'd0);
        check({where, ".ld_rdata"},  ld_rdata,       32'd0);
        check({where, ".mem_en"},    32'(mem_en),    32'd0);
        check({where, ".mem_we"},    32'(mem_we),    32'd0);
        check({where, ".mem_idx"},   32'(mem_idx),   32'd0);
        check({where, ".mem_wdata"}, mem_wdata,      32'd0);
    endtask

    // One clock cycle: drive requests, check grants/memory and the due response, advance the model.
    task automatic step(input logic i_req, input logic [31:0] i_addr,
                        input logic l_req, input logic l_we,
                        input logic [31:0] l_addr, input logic [31:0] l_wdata);
        logic        e_ld;
        logic        e_if;
        logic [31:0] a;
        logic        we;
        logic        ok;
        logic        e_en;
        int          idx;
        @(negedge clk);
        if_req   = i_req;
        if_addr  = i_addr;
        ld_req   = l_req;
        ld_we    = l_we;
        ld_addr  = l_addr;
        ld_wdata = l_wdata;
        #1;
        e_ld = l_req && (!i_req || wait_cnt >= int'(STARVE_MAX));
        e_if = i_req && !e_ld;
        a    = e_ld ? l_addr : i_addr;
        we   = e_ld && l_we;
        ok   = addr_ok(a);
        e_en = (e_if || e_ld) && ok;
        idx  = int'((a - BASE) / 32'd4);
        check("if_gnt", 32'(if_gnt), 32'(e_if));
        check("ld_gnt", 32'(ld_gnt), 32'(e_ld));
        check("mem_en", 32'(mem_en), 32'(e_en));
        check("mem_we", 32'(mem_we), 32'(e_en && we));
        if (e_en) check("mem_idx", 32'(mem_idx), 32'(idx));
        if (e_en && we) check("mem_wdata", mem_wdata, l_wdata);
        check("if_rvalid", 32'(if_rvalid), 32'(pend_owner == 1));
        check("if_err",    32'(if_err),    32'(pend_owner == 1 && pend_err));
        check("if_rdata",  if_rdata,       (pend_owner == 1) ? pend_data : 32'd0);
        check("ld_rvalid", 32'(ld_rvalid), 32'(pend_owner == 2));
        check("ld_err",    32'(ld_err),    32'(pend_owner == 2 && pend_err));
        check("ld_rdata",  ld_rdata,       (pend_owner == 2) ? pend_data : 32'd0);
        if (l_req && !e_ld) wait_cnt = (wait_cnt < int'(STARVE_MAX)) ? wait_cnt + 1 : wait_cnt;
        else                wait_cnt = 0;
        pend_owner = e_if ? 1 : (e_ld ? 2 : 0);
        pend_err   = !ok;
        pend_data  = (!ok || we) ? 32'd0 : ref_mem[idx];
        if (e_en && we) ref_mem[idx] = l_wdata;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] bad [3];
        logic [31:0] v;
        for (int i = 0; i < int'(WORDS); i++) begin
            v = $urandom;
            sim_mem[i] = v;
            ref_mem[i] = v;
        end
        sim_mem[1] = 32'h2408_0001;
        ref_mem[1] = 32'h2408_0001;

        // Reset with both requesters active: everything must stay quiet.
        reset    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h3004;
        ld_req   = 1'b1;
        ld_we    = 1'b1;
        ld_addr  = 32'h3008;
        ld_wdata = 32'h1234_5678;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_all_zero("reset");
        end
        @(posedge clk);
        #1 reset = 1'b1;

        // Simple fetch of word 1.
        step(1'b1, 32'h3004, 1'b0, 1'b0, 32'd0, 32'd0);
        check("fetch.mem_idx", 32'(mem_idx), 32'd1);
        idle();
        check("fetch.if_rvalid", 32'(if_rvalid), 32'd1);
        check("fetch.if_rdata", if_rdata, 32'h2408_0001);

        // Contention: fetch wins four times, loader forced on the fifth.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'(32'h3000 + 32'(4 * i)), 1'b1, 1'b0, 32'h3020, 32'd0);
            check("contend.ld_gnt", 32'(ld_gnt), 32'(i == 4));
            check("contend.if_gnt", 32'(if_gnt), 32'(i != 4));
        end
        idle();

        // Loader write then immediate fetch of the same word.
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'h3010, 32'hDEAD_BEEF);
        step(1'b1, 32'h3010, 1'b0, 1'b0, 32'd0, 32'd0);
        check("ldwr.ld_rvalid", 32'(ld_rvalid), 32'd1);
        check("ldwr.ld_rdata", ld_rdata, 32'd0);
        idle();
        check("ldfetch.if_rdata", if_rdata, 32'hDEAD_BEEF);

        // Out-of-window and misaligned fetches.
        bad[0] = 32'h2FFC;
        bad[1] = 32'h3002;
        bad[2] = 32'h7000;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, bad[i], 1'b0, 1'b0, 32'd0, 32'd0);
            check("bad.mem_en", 32'(mem_en), 32'd0);
            idle();
            check("bad.if_err", 32'(if_err), 32'd1);
            check("bad.if_rdata", if_rdata, 32'd0);
        end

        // Reset lands while a fetch response is in flight.
        step(1'b1, 32'h3004, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_cnt   = 0;
        pend_owner = 0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check_all_zero("rst_mid");
        end
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b1, 32'h3008, 1'b0, 1'b0, 32'd0, 32'd0);
        check("rst_rel.if_gnt", 32'(if_gnt), 32'd1);
        idle();

        // Randomized traffic, mostly to a small window so writes get read back.
        for (int n = 0; n < 400; n++) begin
            logic        ir;
            logic        lr;
            logic [31:0] ia;
            logic [31:0] la;
            ir = ($urandom_range(0, 3) != 0);
            lr = ($urandom_range(0, 2) != 0);
            ia = ($urandom_range(0, 7) == 0) ? bad[$urandom_range(0, 2)]
                                             : BASE + 32'(4 * $urandom_range(0, 15));
            la = ($urandom_range(0, 7) == 0) ? bad[$urandom_range(0, 2)]
                                             : BASE + 32'(4 * $urandom_range(0, 15));
            step(ir, ia, lr, 1'($urandom_range(0, 1)), la, $urandom);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
